spu_result_sram_writer: RTL and testbench
=========================================

// Module: spu_result_sram_writer
// PURPOSE
//  Sink end of the SPU output stream. Accepts m_data0/m_data1/m_valid from stream_processing_unit,
//  writes each valid word pair to two SRAM write ports at the same sequential address.
//  Started per job by the controller; reports busy/done and a sticky error for unexpected traffic.
//  The SPU has no backpressure, so this block accepts every valid beat while running.
// PARAMETERS
//  DATA_BITS   64       width of each data lane (matches SPU DATA_BITS)
//  ADDR_BITS   10       SRAM word address width
//  COUNT_BITS  16       width of the job word counter
//  DEVICE      "RTL"    device name, passed through
//  SIMULATION  "false"  simulation switch
//  DEBUG       "false"  debug switch
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous active-high reset
//  cke          in   1           clock enable; 0 freezes all state, inputs ignored
//  start        in   1           job start pulse
//  base_addr    in   ADDR_BITS   first write address, sampled on accepted start
//  word_count   in   COUNT_BITS  beats in the job, sampled on accepted start
//  busy         out  1           job in progress
//  done         out  1           job finished; held until next accepted start
//  error        out  1           sticky protocol error; cleared by accepted start
//  s_data0      in   DATA_BITS   lane 0 from SPU m_data0
//  s_data1      in   DATA_BITS   lane 1 from SPU m_data1
//  s_valid      in   1           beat valid from SPU m_valid
//  m_wr_en      out  1           SRAM write strobe, both banks
//  m_wr_addr    out  ADDR_BITS   SRAM write address
//  m_wr_data0   out  DATA_BITS   bank 0 write data
//  m_wr_data1   out  DATA_BITS   bank 1 write data
// BEHAVIOUR
//  - All outputs are registered. A beat with cke=1 is one "cycle".
//  - Reset values: busy=0, done=0, error=0, m_wr_en=0, m_wr_addr=0, data=0. State is IDLE.
//  - FSM states:
//    - IDLE/DONE: start with word_count!=0 -> RUN. Latch addr=base_addr and remaining=word_count.
//      Set busy=1, done=0, error=0.
//    - IDLE/DONE: start with word_count==0 -> DONE next cycle, with done=1, busy=0, error=0.
//      No writes are issued.
//    - RUN: each s_valid gives m_wr_en=1 the next cycle, with m_wr_addr=addr and
//      m_wr_data0/1 = the inputs. Then addr+1 and remaining-1.
//    - RUN: the beat with remaining==1 -> DONE next cycle, concurrent with the last write strobe.
//      busy=0 and done=1 in that same cycle.
//  - Latency: s_valid in cycle N -> m_wr_en in cycle N+1. m_wr_en is a single-cycle pulse per beat.
//  - Address wraps modulo 2^ADDR_BITS (e.g. 0x3FF -> 0x000) without error.
//  - s_valid in IDLE/DONE: beat dropped, no write, error<=1.
//  - start during RUN: ignored (job parameters unchanged), error<=1.
//  - start and s_valid in the same IDLE/DONE cycle: the job starts, the beat is dropped,
//    and error ends at 1 (set wins over clear).
//  - cke=0: no state change. m_wr_en is forced to 0 on that cycle, so the write is not repeated.
//  - Reset mid-job: immediate return to reset values. No write is issued in the cycle after reset.
// CONFIGURATION
//  SPU_RESULT_WRITER_CHECKSUM_EN:
//    - Defined: adds outputs chk0/chk1 [DATA_BITS-1:0]. Each is the XOR of every lane-0/lane-1 word
//      written in the current job. Cleared to 0 on accepted start and on reset. Final value is valid
//      while done=1.
//    - Undefined: the ports and logic are absent. Function and timing are otherwise identical.
// TESTING
//  1. Basic job: base=0x010, count=4, beats d0=1..4, d1=0x11..0x14.
//     -> writes at 0x010..0x013 with matching data, each 1 cycle after its s_valid.
//     -> done=1 in the cycle of the 4th write strobe; error=0.
//  2. Wrap: base=0x3FE, count=3 -> addresses 0x3FE, 0x3FF, 0x000; error=0.
//  3. Gapped valid: count=3, valid pattern 1,0,0,1,cke=0,1.
//     -> exactly 3 writes, none during the cke=0 cycle; done after the 3rd.
//  4. Stray traffic: s_valid while IDLE -> no write, error=1.
//     Next start clears error=0; start during RUN -> error=1 and count unchanged.
//  5. Zero count and reset: start with count=0 -> done=1 next cycle, no write.
//     Reset after 2 of 5 beats -> all outputs 0; a later s_valid gives no write and error=1.
//  6. With checksum macro: d0={0x0F,0xF0,0xFF} -> chk0=0x00. Without it, the build has no chk ports.

Source files
------------

// File: rtl/spu_result_sram_writer.sv
// Sink for the SPU output stream: writes each valid lane pair to two SRAM banks at sequential addresses.
// Optional feature macro SPU_RESULT_WRITER_CHECKSUM_EN adds per-job XOR checksums chk0/chk1.
module spu_result_sram_writer #(
    parameter int    DATA_BITS  = 64,
    parameter int    ADDR_BITS  = 10,
    parameter int    COUNT_BITS = 16,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [COUNT_BITS-1:0] word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [DATA_BITS-1:0]  s_data0,
    input  logic [DATA_BITS-1:0]  s_data1,
    input  logic                  s_valid,
    output logic                  m_wr_en,
    output logic [ADDR_BITS-1:0]  m_wr_addr,
    output logic [DATA_BITS-1:0]  m_wr_data0,
    output logic [DATA_BITS-1:0]  m_wr_data1
`ifdef SPU_RESULT_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_BITS-1:0]  chk0,
    output logic [DATA_BITS-1:0]  chk1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [ADDR_BITS-1:0]  addr;
    logic [COUNT_BITS-1:0] remaining;

    logic running;
    logic wr_beat;
    logic job_start;

    assign running   = (state == ST_RUN);
    assign wr_beat   = running && s_valid;
    assign job_start = !running && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            m_wr_en    <= 1'b0;
            m_wr_addr  <= '0;
            m_wr_data0 <= '0;
            m_wr_data1 <= '0;
        end else if (!cke) begin
            // Frozen cycle: drop the strobe so a pending write is not issued twice.
            m_wr_en <= 1'b0;
        end else begin
            m_wr_en <= 1'b0;
            if (running) begin
                if (start)
                    error <= 1'b1;
                if (s_valid) begin
                    m_wr_en    <= 1'b1;
                    m_wr_addr  <= addr;
                    m_wr_data0 <= s_data0;
                    m_wr_data1 <= s_data1;
                    addr       <= addr + 1'b1;
                    remaining  <= remaining - 1'b1;
                    if (remaining == COUNT_BITS'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end else begin
                if (start) begin
                    // A stray beat in the start cycle still flags an error: set wins over clear.
                    error <= s_valid;
                    if (word_count != '0) begin
                        state     <= ST_RUN;
                        addr      <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else if (s_valid) begin
                    error <= 1'b1;
                end
            end
        end
    end

`ifdef SPU_RESULT_WRITER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chk0 <= '0;
            chk1 <= '0;
        end else if (cke) begin
            if (job_start) begin
                chk0 <= '0;
                chk1 <= '0;
            end else if (wr_beat) begin
                chk0 <= chk0 ^ s_data0;
                chk1 <= chk1 ^ s_data1;
            end
        end
    end
`else
    // Checksum disabled: no extra state; job_start/wr_beat feed only the debug check below.
`endif

    generate
        if (SIMULATION == "true" && DEBUG == "true" && DEVICE != "") begin : g_dbg
            // A write strobe can only follow a RUN-state beat, so the job is live or just finished.
            always_ff @(posedge clk) begin
                if (!reset && m_wr_en)
                    assert (busy || done);
                if (!reset && cke && job_start && wr_beat)
                    assert (1'b0);
            end
        end
    endgenerate

endmodule

// File: tb/tb_spu_result_sram_writer.sv
// Directed bench for spu_result_sram_writer; checks strobes, addresses, data and status per cycle.
module tb_spu_result_sram_writer;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, cke, start, s_valid;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [DW-1:0] s_data0, s_data1;
    logic          busy, done, error, m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data0, m_wr_data1;
`ifdef SPU_RESULT_WRITER_CHECKSUM_EN
    logic [DW-1:0] chk0, chk1;
`endif

    int checks = 0;
    int failures = 0;

    spu_result_sram_writer #(.DATA_BITS(DW), .ADDR_BITS(AW), .COUNT_BITS(CW)) dut (
        .clk(clk), .reset(reset), .cke(cke), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
        .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr),
        .m_wr_data0(m_wr_data0), .m_wr_data1(m_wr_data1)
`ifdef SPU_RESULT_WRITER_CHECKSUM_EN
        , .chk0(chk0), .chk1(chk1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are examined 1 time unit after the edge that registered them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        start = 1'b1; base_addr = b; word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        s_valid = 1'b1; s_data0 = d0; s_data1 = d1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        check({tag, ".wr_en"}, 64'(m_wr_en), 64'd1);
        check({tag, ".addr"}, 64'(m_wr_addr), 64'(a));
        check({tag, ".d0"}, m_wr_data0, d0);
        check({tag, ".d1"}, m_wr_data1, d1);
    endtask

    task automatic expect_status(input string tag, input logic b, input logic d, input logic e);
        check({tag, ".busy"}, 64'(busy), 64'(b));
        check({tag, ".done"}, 64'(done), 64'(d));
        check({tag, ".error"}, 64'(error), 64'(e));
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; start = 1'b0; s_valid = 1'b0;
        base_addr = '0; word_count = '0; s_data0 = '0; s_data1 = '0;
        tick(); tick();
        expect_status("rst", 1'b0, 1'b0, 1'b0);
        check("rst.wr_en", 64'(m_wr_en), 64'd0);
        check("rst.addr", 64'(m_wr_addr), 64'd0);
        check("rst.d0", m_wr_data0, 64'd0);
        reset = 1'b0;
        tick();

        // Basic job
        do_start(10'h010, 16'd4);
        expect_status("t1.start", 1'b1, 1'b0, 1'b0);
        check("t1.start.wr_en", 64'(m_wr_en), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            beat(64'(i), 64'(16 + i));
            expect_wr("t1.beat", 10'(16 + i - 1), 64'(i), 64'(16 + i));
        end
        expect_status("t1.last", 1'b0, 1'b1, 1'b0);
        tick();
        check("t1.idle.wr_en", 64'(m_wr_en), 64'd0);
        expect_status("t1.hold", 1'b0, 1'b1, 1'b0);

        // Address wrap
        do_start(10'h3FE, 16'd3);
        beat(64'hA, 64'hB); expect_wr("t2.w0", 10'h3FE, 64'hA, 64'hB);
        beat(64'hC, 64'hD); expect_wr("t2.w1", 10'h3FF, 64'hC, 64'hD);
        beat(64'hE, 64'hF); expect_wr("t2.w2", 10'h000, 64'hE, 64'hF);
        expect_status("t2.end", 1'b0, 1'b1, 1'b0);

        // Gapped valid and clock enable
        do_start(10'h020, 16'd3);
        beat(64'h1, 64'h2); expect_wr("t3.w0", 10'h020, 64'h1, 64'h2);
        tick(); check("t3.gap0", 64'(m_wr_en), 64'd0);
        tick(); check("t3.gap1", 64'(m_wr_en), 64'd0);
        beat(64'h3, 64'h4); expect_wr("t3.w1", 10'h021, 64'h3, 64'h4);
        cke = 1'b0;
        beat(64'h99, 64'h99);
        check("t3.cke0.wr_en", 64'(m_wr_en), 64'd0);
        expect_status("t3.cke0", 1'b1, 1'b0, 1'b0);
        cke = 1'b1;
        beat(64'h5, 64'h6); expect_wr("t3.w2", 10'h022, 64'h5, 64'h6);
        expect_status("t3.end", 1'b0, 1'b1, 1'b0);

        // Stray traffic
        beat(64'h7, 64'h7);
        check("t4.stray.wr_en", 64'(m_wr_en), 64'd0);
        check("t4.stray.err", 64'(error), 64'd1);
        do_start(10'h040, 16'd2);
        expect_status("t4.restart", 1'b1, 1'b0, 1'b0);
        do_start(10'h080, 16'd9);
        expect_status("t4.start_run", 1'b1, 1'b0, 1'b1);
        beat(64'h21, 64'h22); expect_wr("t4.w0", 10'h040, 64'h21, 64'h22);
        beat(64'h23, 64'h24); expect_wr("t4.w1", 10'h041, 64'h23, 64'h24);
        expect_status("t4.end", 1'b0, 1'b1, 1'b1);
        // Start and stray beat together: job starts, beat dropped, error set
        start = 1'b1; base_addr = 10'h050; word_count = 16'd1; s_valid = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b0;
        check("t4.both.wr_en", 64'(m_wr_en), 64'd0);
        expect_status("t4.both", 1'b1, 1'b0, 1'b1);
        beat(64'h31, 64'h32); expect_wr("t4.both.w", 10'h050, 64'h31, 64'h32);
        expect_status("t4.both.end", 1'b0, 1'b1, 1'b1);

        // Zero count, then reset mid-job
        do_start(10'h100, 16'd0);
        check("t5.zero.wr_en", 64'(m_wr_en), 64'd0);
        expect_status("t5.zero", 1'b0, 1'b1, 1'b0);
        do_start(10'h000, 16'd5);
        beat(64'h41, 64'h42); expect_wr("t5.w0", 10'h000, 64'h41, 64'h42);
        beat(64'h43, 64'h44); expect_wr("t5.w1", 10'h001, 64'h43, 64'h44);
        reset = 1'b1; s_valid = 1'b1;
        tick();
        reset = 1'b0; s_valid = 1'b0;
        expect_status("t5.rst", 1'b0, 1'b0, 1'b0);
        check("t5.rst.wr_en", 64'(m_wr_en), 64'd0);
        check("t5.rst.addr", 64'(m_wr_addr), 64'd0);
        check("t5.rst.d1", m_wr_data1, 64'd0);
        beat(64'h55, 64'h55);
        check("t5.after.wr_en", 64'(m_wr_en), 64'd0);
        check("t5.after.err", 64'(error), 64'd1);

`ifdef SPU_RESULT_WRITER_CHECKSUM_EN
        do_start(10'h010, 16'd3);
        check("t6.clr0", chk0, 64'd0);
        beat(64'h0F, 64'h1);
        beat(64'hF0, 64'h2);
        beat(64'hFF, 64'h4);
        check("t6.done", 64'(done), 64'd1);
        check("t6.chk0", chk0, 64'h00);
        check("t6.chk1", chk1, 64'h07);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
